// File: rtl/thread_fetch_sched_if.sv
// Fetch-scheduler handshake bundle: run/stall controls, thread mask, redirect
// request, and the registered fetch issue outputs.
interface thread_fetch_sched_if #(
  parameter int unsigned PC_WIDTH = 64
);
  logic                en;
  logic                stall;
  logic [3:0]          thread_active;
  logic                redirect_valid;
  logic [3:0]          redirect_thread;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                fetch_valid;
  logic [3:0]          thread_sel_IF;
  logic [PC_WIDTH-1:0] pc_IF;

  modport master (
    output en, stall, thread_active, redirect_valid, redirect_thread, redirect_pc,
    input  fetch_valid, thread_sel_IF, pc_IF
  );

  modport slave (
    input  en, stall, thread_active, redirect_valid, redirect_thread, redirect_pc,
    output fetch_valid, thread_sel_IF, pc_IF
  );
endinterface

// File: rtl/thread_fetch_sched.sv
// Four-thread round-robin fetch scheduler with per-thread PCs, redirects that
// override increments, and registered issue outputs.
module thread_fetch_sched #(
  parameter int unsigned               PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]       RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0]       PC_INC   = PC_WIDTH'(4)
) (
  input  logic                 clk,
  input  logic                 reset,
  thread_fetch_sched_if.slave  bus
);

  function automatic logic is_onehot4(input logic [3:0] v);
    is_onehot4 = (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  logic [PC_WIDTH-1:0] pc_r [4];
  logic [1:0]          last_sel_r;
  logic                fetch_valid_r;
  logic [3:0]          thread_sel_r;
  logic [PC_WIDTH-1:0] pc_if_r;

  logic                redir_ok_s;
  logic [3:0]          redir_mask_s;
  logic [3:0]          eligible_s;
  logic                found_s;
  logic [1:0]          sel_idx_s;
  logic                issue_s;
  logic                take_s;

  // Eligibility: a well-formed redirect blocks its own thread for this edge.
  always_comb begin
    redir_ok_s   = bus.redirect_valid && is_onehot4(bus.redirect_thread);
    redir_mask_s = redir_ok_s ? bus.redirect_thread : 4'b0000;
    eligible_s   = bus.thread_active & ~redir_mask_s;
    issue_s      = bus.en && !bus.stall;
    found_s      = (eligible_s != 4'b0000);
    take_s       = issue_s && found_s;
  end

  // Round-robin pick: walk from farthest to nearest so the nearest eligible wins.
  always_comb begin
    logic [1:0] cand;
    sel_idx_s = last_sel_r;
    for (int k = 4; k >= 1; k--) begin
      cand      = last_sel_r + 2'(k);
      sel_idx_s = eligible_s[cand] ? cand : sel_idx_s;
    end
  end

  // Per-thread PC update: redirect beats increment (they never coincide on one thread).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pc_r[i] <= RESET_PC;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (redir_mask_s[i]) begin
          pc_r[i] <= bus.redirect_pc;
        end else if (take_s && (sel_idx_s == 2'(i))) begin
          pc_r[i] <= pc_r[i] + PC_INC;
        end else begin
          pc_r[i] <= pc_r[i];
        end
      end
    end
  end

  // Issue registers and last-issued pointer; stall freezes everything here.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sel_r    <= 2'd3;
      fetch_valid_r <= 1'b0;
      thread_sel_r  <= 4'b0000;
      pc_if_r       <= '0;
    end else if (bus.stall) begin
      last_sel_r    <= last_sel_r;
      fetch_valid_r <= fetch_valid_r;
      thread_sel_r  <= thread_sel_r;
      pc_if_r       <= pc_if_r;
    end else if (take_s) begin
      last_sel_r    <= sel_idx_s;
      fetch_valid_r <= 1'b1;
      thread_sel_r  <= 4'b0001 << sel_idx_s;
      pc_if_r       <= pc_r[sel_idx_s];
    end else begin
      last_sel_r    <= last_sel_r;
      fetch_valid_r <= 1'b0;
      thread_sel_r  <= 4'b0000;
      pc_if_r       <= '0;
    end
  end

  assign bus.fetch_valid   = fetch_valid_r;
  assign bus.thread_sel_IF = thread_sel_r;
  assign bus.pc_IF         = pc_if_r;

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Scoreboard bench: a behavioural scheduler model predicts each edge's outputs,
// a negedge monitor compares them against the DUT.
module tb_thread_fetch_sched;
  localparam int PCW = 64;

  typedef struct packed {
    logic           valid;
    logic [3:0]     sel;
    logic [PCW-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  thread_fetch_sched_if #(.PC_WIDTH(PCW)) bus();

  thread_fetch_sched #(.PC_WIDTH(PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state
  logic [PCW-1:0] m_pc [4];
  int             m_last;
  exp_t           m_out;

  task automatic model_edge(input logic rst, input logic en, input logic stall,
                            input logic [3:0] act, input logic rv,
                            input logic [3:0] rt, input logic [PCW-1:0] rpc);
    int  rthread;
    bit  rok;
    int  pick;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_pc[i] = '0;
      m_last = 3;
      m_out  = '0;
      return;
    end
    rok = rv && ($countones(rt) == 1);
    rthread = -1;
    for (int i = 0; i < 4; i++) if (rok && rt[i]) rthread = i;
    pick = -1;
    if (!stall && en) begin
      for (int k = 1; k <= 4 && pick < 0; k++) begin
        int t;
        t = (m_last + k) % 4;
        if (act[t] && t != rthread) pick = t;
      end
    end
    if (!stall) begin
      if (pick >= 0) begin
        m_out.valid = 1'b1;
        m_out.sel   = 4'(1 << pick);
        m_out.pc    = m_pc[pick];
        m_last      = pick;
        m_pc[pick]  = m_pc[pick] + 64'd4;
      end else begin
        m_out = '0;
      end
    end
    if (rthread >= 0) m_pc[rthread] = rpc;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input logic en, input logic stall,
                      input logic [3:0] act, input logic rv,
                      input logic [3:0] rt, input logic [PCW-1:0] rpc);
    @(negedge clk);
    #1;
    reset               = rst;
    bus.en              = en;
    bus.stall           = stall;
    bus.thread_active   = act;
    bus.redirect_valid  = rv;
    bus.redirect_thread = rt;
    bus.redirect_pc     = rpc;
    model_edge(rst, en, stall, act, rv, rt, rpc);
    exp_q.push_back(m_out);
  endtask

  task automatic run(input logic [3:0] act, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, act, 1'b0, 4'b0000, '0);
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.fetch_valid !== e.valid || bus.thread_sel_IF !== e.sel || bus.pc_IF !== e.pc) begin
        failures++;
        $display("FAIL sb cyc=%0d got v=%0b sel=%b pc=%h exp v=%0b sel=%b pc=%h",
                 cyc, bus.fetch_valid, bus.thread_sel_IF, bus.pc_IF, e.valid, e.sel, e.pc);
      end
    end
  end

  initial begin
    logic [PCW-1:0] rpc;
    logic [3:0]     rt;
    reset = 1'b1;
    bus.en = 1'b0; bus.stall = 1'b0; bus.thread_active = 4'b0000;
    bus.redirect_valid = 1'b0; bus.redirect_thread = 4'b0000; bus.redirect_pc = '0;

    // Reset and plain round robin
    step(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, '0);
    step(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, '0);
    run(4'b1111, 5);

    // Masking, then nothing eligible
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, '0);
    run(4'b0101, 4);
    run(4'b0000, 2);

    // Stall after thread 1 issues
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, '0);
    run(4'b1111, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, '0);
    run(4'b1111, 4);

    // Redirect collides with thread 0's turn
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, '0);
    step(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0001, 64'h100);
    run(4'b1111, 8);

    // Wrap, then a malformed redirect
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, '0);
    step(1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFC);
    run(4'b0001, 2);
    step(1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0011, 64'hDEAD);
    run(4'b0001, 2);

    // Reset during stall with a pending redirect
    run(4'b1111, 3);
    step(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 64'h500);
    step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 64'h600);
    run(4'b1111, 3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rt  = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      rpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                        : {32'($urandom), 32'($urandom)};
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) == 0, 4'($urandom),
           $urandom_range(0, 6) == 0, rt, rpc);
    end

    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
